// File: rtl/wide_add_sequencer_pkg.sv
// Shared types for the wide add/subtract sequencer.
// Word width and FSM state encoding live here.
package wide_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/wide_add_sequencer_csa_adder.sv
// 32-bit carry-select adder: ripple low half, select the
// precomputed high half on the low-half carry.
module csa_adder
  import wide_add_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  localparam int H = WORD_W / 2;

  logic [H:0] lo;
  logic [H:0] hi0;
  logic [H:0] hi1;

  assign lo  = {1'b0, a_i[H-1:0]}
             + {1'b0, b_i[H-1:0]}
             + {{H{1'b0}}, cin_i};
  assign hi0 = {1'b0, a_i[WORD_W-1:H]}
             + {1'b0, b_i[WORD_W-1:H]};
  assign hi1 = hi0 + (H+1)'(1);

  assign sum_o[H-1:0] = lo[H-1:0];
  assign {cout_o, sum_o[WORD_W-1:H]} = lo[H] ? hi1 : hi0;

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-word add/subtract built from one shared 32-bit adder,
// stepping LS word first with the carry held in a register.
module wide_add_sequencer
  import wide_add_pkg::*;
#(
  parameter int NWORDS = 4,
  parameter int CW     = $clog2(NWORDS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [32*NWORDS-1:0]     in_a,
  input  logic [32*NWORDS-1:0]     in_b,
  input  logic                     in_sub,
  input  logic                     in_cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [32*NWORDS-1:0]     out_sum,
  output logic                     out_cout,
  output logic                     out_ovf,
  output logic                     busy
);

  state_e state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic carry_q, carry_d;
  logic cout_q, cout_d;
  logic ovf_q, ovf_d;
  logic vld_q, vld_d;
  logic [NWORDS-1:0][WORD_W-1:0] a_q, a_d;
  logic [NWORDS-1:0][WORD_W-1:0] b_q, b_d;
  logic [NWORDS-1:0][WORD_W-1:0] sum_q, sum_d;

  logic [WORD_W-1:0] add_s;
  logic              add_co;
  logic              last;
  logic              a_msb;
  logic              b_msb;

  csa_adder u_add (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .cin_i  (carry_q),
    .sum_o  (add_s),
    .cout_o (add_co)
  );

  assign last  = (idx_q == CW'(NWORDS-1));
  assign a_msb = a_q[NWORDS-1][WORD_W-1];
  assign b_msb = b_q[NWORDS-1][WORD_W-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_sub ? ~in_b : in_b;
          carry_d = in_sub ? 1'b1 : in_cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = add_s;
        carry_d      = add_co;
        if (last) begin
          cout_d  = add_co;
          ovf_d   = (a_msb == b_msb)
                 && (add_s[WORD_W-1] != a_msb);
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        // out_valid is registered, so it rises one edge into DONE
        vld_d = 1'b1;
        if (vld_q && out_ready) begin
          vld_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer (NWORDS=4).
// Expected values are hand-computed or from a flat 129-bit model.
module tb_wide_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 32 * NW;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  int nvec  = 0;
  int nfail = 0;
  int nacc  = 0;
  int nres  = 0;

  always #5 clk = ~clk;

  wide_add_sequencer #(.NWORDS(NW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) nacc++;
    if (!rst && out_valid && out_ready) nres++;
  end

  function automatic logic [W-1:0] rnd128();
    logic [W-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    case ($urandom_range(0, 7))
      0: v = '1;
      1: v = '0;
      2: v = {1'b0, {(W-1){1'b1}}};
      3: v = {1'b1, {(W-1){1'b0}}};
      default: ;
    endcase
    return v;
  endfunction

  // Drive one request, wait for result, hold out_ready low rdly cycles.
  task automatic run_op(
    input  logic [W-1:0] a, b,
    input  logic         sub, cin,
    input  int           rdly,
    output logic [W-1:0] s,
    output logic         co, ov,
    output int           lat,
    output bit           to
  );
    int n;
    to = 0; lat = 0; n = 0;
    s = '0; co = 0; ov = 0;
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_cin = cin;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      in_valid = 1'b0;
      to = 1;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_sub = ~sub; in_cin = ~cin;
    while (lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) begin
      to = 1;
      return;
    end
    s = out_sum; co = out_cout; ov = out_ovf;
    repeat (rdly) @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_a = '0; in_b = '0;
    in_sub = 0; in_cin = 0; out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL rst_in_ready got %b want 1", in_ready);
    end
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    end
    nvec++;
    if (busy !== 1'b0) begin
      nfail++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    nvec++;
    if ({out_sum, out_cout, out_ovf} !== '0) begin
      nfail++;
      $display("FAIL rst_outputs got %h %b %b want 0",
               out_sum, out_cout, out_ovf);
    end
    rst = 1'b0;
  endtask

  task automatic test_vec(
    input string nm,
    input logic [W-1:0] a, b,
    input logic sub, cin,
    input logic [W-1:0] es,
    input logic eco, eov
  );
    logic [W-1:0] s;
    logic co, ov;
    int lat;
    bit to;
    run_op(a, b, sub, cin, 0, s, co, ov, lat, to);
    nvec++;
    if (to) begin
      nfail++;
      $display("FAIL %s timeout got 1 want 0", nm);
      return;
    end
    nvec++;
    if (s !== es) begin
      nfail++;
      $display("FAIL %s sum got %h want %h", nm, s, es);
    end
    nvec++;
    if (co !== eco) begin
      nfail++;
      $display("FAIL %s cout got %b want %b", nm, co, eco);
    end
    nvec++;
    if (ov !== eov) begin
      nfail++;
      $display("FAIL %s ovf got %b want %b", nm, ov, eov);
    end
    nvec++;
    if (lat !== 5) begin
      nfail++;
      $display("FAIL %s latency got %0d want 5", nm, lat);
    end
  endtask

  task automatic test_carry_ripple();
    test_vec("ripple",
      128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
      128'h1, 1'b0, 1'b0,
      128'h0000_0001_0000_0000_0000_0000_0000_0000,
      1'b0, 1'b0);
  endtask

  task automatic test_subtract();
    test_vec("sub_5_7", 128'd5, 128'd7, 1'b1, 1'b0,
      128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE,
      1'b0, 1'b0);
    test_vec("sub_7_5", 128'd7, 128'd5, 1'b1, 1'b1,
      128'd2, 1'b1, 1'b0);
  endtask

  task automatic test_overflow_cin();
    test_vec("ovf_pos",
      128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
      128'd1, 1'b0, 1'b0,
      128'h8000_0000_0000_0000_0000_0000_0000_0000,
      1'b0, 1'b1);
    test_vec("cin_wrap",
      128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
      128'd0, 1'b0, 1'b1,
      128'd0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure();
    int n;
    bit bad;
    @(negedge clk);
    in_a = 128'd100; in_b = 128'd200;
    in_sub = 0; in_cin = 0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_a = 128'd10; in_b = 128'd3; in_sub = 1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    nvec++;
    if (out_valid !== 1'b1) begin
      nfail++;
      $display("FAIL bp_first_valid got %b want 1", out_valid);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || out_sum !== 128'd300
          || in_ready !== 1'b0 || out_cout !== 1'b0) bad = 1;
    end
    nvec++;
    if (bad) begin
      nfail++;
      $display("FAIL bp_hold got vld=%b sum=%0d rdy=%b want 1 300 0",
               out_valid, out_sum, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    nvec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      nfail++;
      $display("FAIL bp_release got vld=%b rdy=%b want 0 1",
               out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    nvec++;
    if ({in_ready, busy} !== 2'b01) begin
      nfail++;
      $display("FAIL bp_second_accept got rdy=%b busy=%b want 0 1",
               in_ready, busy);
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    nvec++;
    if ({out_valid, out_sum, out_cout} !== {1'b1, 128'd7, 1'b1}) begin
      nfail++;
      $display("FAIL bp_second got vld=%b sum=%0d co=%b want 1 7 1",
               out_valid, out_sum, out_cout);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    in_a = 128'd3; in_b = 128'd4;
    in_sub = 0; in_cin = 0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    nvec++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      nfail++;
      $display("FAIL rmid_ctrl got vld=%b rdy=%b busy=%b want 0 1 0",
               out_valid, in_ready, busy);
    end
    nvec++;
    if (out_sum !== '0) begin
      nfail++;
      $display("FAIL rmid_sum got %h want 0", out_sum);
    end
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      nfail++;
      $display("FAIL rmid_ghost got %b want 0", seen);
    end
    test_vec("rmid_3p4", 128'd3, 128'd4, 1'b0, 1'b0,
      128'd7, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, be, s;
    logic [W:0] r;
    logic sub, cin, co, ov, eov;
    int lat, acc0, res0, errs;
    bit to;
    acc0 = nacc; res0 = nres;
    for (int i = 0; i < 1000; i++) begin
      a = rnd128(); b = rnd128();
      sub = 1'($urandom_range(0, 1));
      cin = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_op(a, b, sub, cin, $urandom_range(0, 3),
             s, co, ov, lat, to);
      be  = sub ? ~b : b;
      r   = {1'b0, a} + {1'b0, be}
          + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      eov = (a[W-1] == be[W-1]) && (r[W-1] != a[W-1]);
      nvec++;
      if (to || {co, s} !== r || ov !== eov) begin
        nfail++;
        errs++;
        if (errs < 10)
          $display("FAIL rand_%0d got %b %h %b to=%b want %h %b",
                   i, co, s, ov, to, r, eov);
      end
    end
    repeat (4) @(posedge clk);
    nvec++;
    if (nacc - acc0 !== 1000 || nres - res0 !== 1000) begin
      nfail++;
      $display("FAIL rand_count got acc=%0d res=%0d want 1000 1000",
               nacc - acc0, nres - res0);
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_subtract();
    test_overflow_cin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle controller that performs NWORDS×32-bit add/subtract by sequencing one shared 32-bit carry-select adder (CSA_ADDER), least-significant word first.
- Carry is chained between words through a register.
- Sits between an operand-issuing client (valid/ready) and a result consumer (valid/ready).
- Used wherever wide arithmetic is needed without replicating the adder.

Parameters:
- NWORDS, 4, number of 32-bit words per operand (≥2); total width is 32*NWORDS.
- CW, $clog2(NWORDS), width of the word index counter.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept a request.
- in_a  input  32*NWORDS  operand A.
- in_b  input  32*NWORDS  operand B.
- in_sub  input  1  1 = A−B, 0 = A+B.
- in_cin  input  1  carry-in for add; ignored when in_sub=1.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_sum  output  32*NWORDS  result.
- out_cout  output  1  carry out of the top word. For subtract, 1 means no borrow.
- out_ovf  output  1  signed two's-complement overflow.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, rst.
- FSM states: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_sum=0, out_cout=0, out_ovf=0, word index=0, carry register=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture in_a, in_sub and the effective B into operand registers. Effective B is ~in_b if in_sub=1, else in_b.
  - Set carry register to 1 if in_sub=1, else in_cin.
  - Clear index, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, drive the adder with A word[idx], B' word[idx] and the carry register.
  - Write the adder sum into out_sum word[idx]. Load the carry register with the adder cout.
  - On idx==NWORDS-1:
    - out_cout = adder cout.
    - out_ovf = (A msb == B' msb) && (sum msb != A msb).
    - Go to DONE.
  - Otherwise idx+1.
  - Exactly NWORDS cycles spent in RUN.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are held stable.
  - On out_ready, out_valid drops next cycle and the FSM returns to IDLE.
  - While out_ready=0, DONE holds indefinitely.
- Latency: request accepted on edge T, out_valid high from edge T+NWORDS+1. Throughput is one request per NWORDS+2 cycles minimum.
- out_sum contents are undefined (partially written) while in RUN. Consumers use only the value present when out_valid=1.
- in_valid asserted during RUN/DONE is not accepted (in_ready=0). The request stays pending and is taken in the next IDLE cycle.
- Input operands may change after acceptance without affecting the result.
- rst in any state returns everything to reset values on the next edge. Any in-flight operation is discarded and no out_valid is produced for it.
- Adder datapath (fixed):
  - The adder is instantiated once and is purely combinational.
  - Each adder evaluation is registered at the end of the same cycle; no multicycle path.
- Width rules: all arithmetic is modulo 2^(32*NWORDS). The carry register is the only inter-word state.

Decomposition:
- Shared package wide_add_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - localparam WORD_W=32.
- Natural sub-module: CSA_ADDER (existing 32-bit carry-select adder), instantiated once. Its own cin is driven from the carry register.
- All sequencing stays in wide_add_sequencer.

Test Plan:
- Carry ripple across all words: NWORDS=4, add, A=128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> out_sum=128'h0000_0001_0000_0000_0000_0000_0000_0000, cout=0, ovf=0. out_valid rises exactly 5 edges after acceptance.
- Subtract with borrow-out: sub, A=5, B=7 -> out_sum=128'hFFFF…FFFE, cout=0 (borrow), ovf=0. Then sub, A=7, B=5 -> out_sum=2, cout=1.
- Signed overflow and carry-in:
  - add, A=128'h7FFF…FFFF, B=1, cin=0 -> out_sum=128'h8000_0000…0, ovf=1, cout=0.
  - add, A=all-ones, B=0, cin=1 -> out_sum=0, cout=1, ovf=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, outputs stable, in_ready=0. A second in_valid held high is accepted only on the cycle after out_ready handshake + return to IDLE.
- Reset mid-operation: assert rst on the 2nd RUN cycle -> next edge state=IDLE, out_valid=0, in_ready=1, out_sum=0. A subsequent add 3+4 yields 7 with normal latency.
- Back-to-back random: 1000 random add/sub requests with random valid/ready gaps -> every result matches a 129-bit reference model (sum, cout, signed ovf). No lost or duplicated transactions.
